hazard_detection_unit: RTL

- Sits beside the decode stage of the 5-stage RISC-V pipeline and consumes the decoder's rs1use, rs2use, hazard_optype and RegWrite signals, plus the ID-stage register addresses and the branch redirect.
- Keeps its own shadow copy of destination register and op-type for the instructions in EX and MEM.
- Produces stall, flush and forwarding selects for the ID-stage operand muxes; branches compare in ID, so forwarding targets ID.

---
 rtl/hazard_detection_unit_pkg.sv | 37 +++
 rtl/hazard_detection_unit_fwd_sel.sv | 45 ++++
 rtl/hazard_detection_unit.sv | 129 ++++++++++++
 3 files changed

// File: rtl/hazard_detection_unit_pkg.sv
// Shared op-type and forward-select codes for the hazard unit.
// Also holds the helper that maps a decoded op onto its shadow type.
package hazard_detection_unit_pkg;

  localparam int ADDR_W = 5;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_ALU   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_STORE = 2'b11
  } optype_e;

  typedef enum logic [1:0] {
    FWD_RF      = 2'b00,
    FWD_EX_ALU  = 2'b01,
    FWD_MEM_ALU = 2'b10,
    FWD_MEM_LD  = 2'b11
  } fwd_sel_e;

  // A non-writing op only keeps its type if it is a store;
  // anything else is recorded as "none".
  function automatic optype_e shadow_type(
    input logic [1:0] op,
    input logic       reg_write
  );
    optype_e t;
    t = optype_e'(op);
    if (t == OP_STORE)
      return OP_STORE;
    else if (reg_write)
      return t;
    else
      return OP_NONE;
  endfunction

endpackage

// File: rtl/hazard_detection_unit_fwd_sel.sv
// Per-operand forward selector for the ID-stage operand muxes.
// Ports: use/addr of one source operand, EX/MEM shadow rd+type, sel out.
module hazard_detection_unit_fwd_sel
  import hazard_detection_unit_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              src_use,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] rd_ex,
  input  logic [1:0]        type_ex,
  input  logic [ADDR_W-1:0] rd_mem,
  input  logic [1:0]        type_mem,
  output logic [1:0]        fwd_sel
);

  logic nz;
  logic hit_ex;
  logic hit_mem;
  logic sel_ex_alu;
  logic sel_mem_alu;
  logic sel_mem_ld;

  assign nz      = src_use && (src_addr != '0);
  assign hit_ex  = nz && (src_addr == rd_ex);
  assign hit_mem = nz && (src_addr == rd_mem);

  // Youngest producer wins, so the MEM terms are masked by an EX ALU hit.
  assign sel_ex_alu  = hit_ex && (type_ex == OP_ALU);
  assign sel_mem_alu = !sel_ex_alu && hit_mem
                       && (type_mem == OP_ALU);
  assign sel_mem_ld  = !sel_ex_alu && hit_mem
                       && (type_mem == OP_LOAD);

  always_comb begin
    fwd_sel = FWD_RF;
    unique case (1'b1)
      sel_ex_alu:  fwd_sel = FWD_EX_ALU;
      sel_mem_alu: fwd_sel = FWD_MEM_ALU;
      sel_mem_ld:  fwd_sel = FWD_MEM_LD;
      default:     fwd_sel = FWD_RF;
    endcase
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// Hazard unit beside decode: load-use stall, redirect flush, ID forwarding.
// Ports: ID regs/uses/optype/RegWrite/redirect in; PC/FD/DE controls and fwd out.
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr_ID,
  input  logic [ADDR_W-1:0] rs2_addr_ID,
  input  logic [ADDR_W-1:0] rd_addr_ID,
  input  logic              rs1use_ID,
  input  logic              rs2use_ID,
  input  logic [1:0]        hazard_optype_ID,
  input  logic              RegWrite_ID,
  input  logic              redirect_ID,
  output logic              PC_EN_IF,
  output logic              reg_FD_EN,
  output logic              reg_FD_flush,
  output logic              reg_DE_flush,
  output logic [1:0]        forward_ctrl_A,
  output logic [1:0]        forward_ctrl_B,
  output logic              forward_ctrl_ls
);

  logic [ADDR_W-1:0] rd_ex;
  logic [ADDR_W-1:0] rd_mem;
  optype_e           type_ex;
  optype_e           type_mem;
  logic              ls_ex;
  logic              ls_mem;

  optype_e           op_id;
  logic              m1_ex;
  logic              m2_ex;
  logic              stall;
  logic              store_ld;
  logic [1:0]        fa;
  logic [1:0]        fb;

  assign op_id = optype_e'(hazard_optype_ID);

  assign m1_ex = rs1use_ID && (rs1_addr_ID != '0)
                 && (rs1_addr_ID == rd_ex);
  assign m2_ex = rs2use_ID && (rs2_addr_ID != '0)
                 && (rs2_addr_ID == rd_ex);

  // A store only needs the loaded value as write data in MEM,
  // which WB can supply, so an rs2-only hit does not stall it.
  assign stall = (type_ex == OP_LOAD)
                 && (m1_ex || (m2_ex && op_id != OP_STORE));

  assign store_ld = (op_id == OP_STORE) && (type_ex == OP_LOAD)
                    && m2_ex && !m1_ex;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ex    <= '0;
      type_ex  <= OP_NONE;
      ls_ex    <= 1'b0;
      rd_mem   <= '0;
      type_mem <= OP_NONE;
      ls_mem   <= 1'b0;
    end else begin
      rd_mem   <= rd_ex;
      type_mem <= type_ex;
      ls_mem   <= ls_ex;
      if (stall) begin
        rd_ex   <= '0;
        type_ex <= OP_NONE;
        ls_ex   <= 1'b0;
      end else begin
        rd_ex   <= RegWrite_ID ? rd_addr_ID : '0;
        type_ex <= shadow_type(hazard_optype_ID, RegWrite_ID);
        ls_ex   <= store_ld;
      end
    end
  end

  hazard_detection_unit_fwd_sel #(
    .ADDR_W (ADDR_W)
  ) u_fwd_a (
    .src_use  (rs1use_ID),
    .src_addr (rs1_addr_ID),
    .rd_ex    (rd_ex),
    .type_ex  (type_ex),
    .rd_mem   (rd_mem),
    .type_mem (type_mem),
    .fwd_sel  (fa)
  );

  hazard_detection_unit_fwd_sel #(
    .ADDR_W (ADDR_W)
  ) u_fwd_b (
    .src_use  (rs2use_ID),
    .src_addr (rs2_addr_ID),
    .rd_ex    (rd_ex),
    .type_ex  (type_ex),
    .rd_mem   (rd_mem),
    .type_mem (type_mem),
    .fwd_sel  (fb)
  );

  // Stall beats redirect: the branch is re-resolved next cycle
  // once its operand can be forwarded.
  always_comb begin
    PC_EN_IF        = 1'b1;
    reg_FD_EN       = 1'b1;
    reg_FD_flush    = 1'b0;
    reg_DE_flush    = 1'b0;
    forward_ctrl_A  = FWD_RF;
    forward_ctrl_B  = FWD_RF;
    forward_ctrl_ls = 1'b0;
    if (rst_n) begin
      forward_ctrl_A  = fa;
      forward_ctrl_B  = fb;
      forward_ctrl_ls = ls_mem;
      if (stall) begin
        PC_EN_IF     = 1'b0;
        reg_FD_EN    = 1'b0;
        reg_DE_flush = 1'b1;
      end else begin
        reg_FD_flush = redirect_ID;
      end
    end
  end

endmodule
